fft_result_serializer: RTL and testbench
========================================

FFT_RESULT_SERIALIZER -- requirements
Module: fft_result_serializer

Interface
REQ-001 SHALL have parameters: DATA_W, 32, output sample width per real/imag part; IDX_W, 11, column index width; DEPTH, 4, beat FIFO depth (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  beat strobe from recover stage; in_col1_r/in_col1_i/in_col2_r/in_col2_i  in  4xDATA_W each  packed lane data; in_index_col1/in_index_col2  in  IDX_W each  column indices.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; out_r/out_i  out  DATA_W each; out_index  out  IDX_W+2  sample index; out_last  out  1  last sample of beat.
REQ-005 SHALL have ports: fifo_count  out  clog2(DEPTH)+1  occupied beats; overflow  out  1  dropped-beat flag.

Function
REQ-006 SHALL store each in_valid beat (8 complex samples plus 2 indices) as one FIFO entry; input side has no backpressure.
REQ-007 SHALL emit samples in order col1 lane0..3 then col2 lane0..3, one per out_valid&&out_ready transfer.
REQ-008 SHALL form out_index = {index_colN, lane[1:0]} of the emitting column.
REQ-009 SHALL assert out_last on the 8th sample (col2 lane3) of each beat only.
REQ-010 SHALL use state machine IDLE (FIFO empty, out_valid=0) and SEND (out_valid=1); IDLE->SEND when count becomes nonzero; SEND->IDLE on last transfer with no further entry.
REQ-011 SHALL present first sample with out_valid high in the cycle after a beat is written to an empty FIFO (1-cycle latency).
REQ-012 SHALL hold out_r, out_i, out_index, out_last stable while out_valid=1 and out_ready=0.
REQ-013 SHALL use 3-bit lane counter, advanced on each transfer, wrapping 7->0 and popping the FIFO entry on wrap.
REQ-014 SHALL, on back-to-back beats, continue from one beat's last sample to next beat's first sample with no bubble.
REQ-015 SHALL, when FIFO full and in_valid=1 with a pop in the same cycle, accept the beat (count unchanged).
REQ-016 SHALL, when FIFO full and in_valid=1 with no pop, drop the beat, leave FIFO contents unchanged, and flag overflow.
REQ-017 SHALL update fifo_count registered: +1 push-only, -1 pop-only, unchanged for both/neither.
REQ-018 SHALL pass data bits unmodified (no rounding, sign handling, or saturation).

Reset
REQ-019 SHALL on rst_n low immediately force: state IDLE, lane counter 0, FIFO pointers 0, fifo_count 0, out_valid 0, out_r/out_i/out_index 0, out_last 0, overflow 0.
REQ-020 SHALL discard any partially emitted beat on reset mid-operation; no sample of it appears after release.
REQ-021 SHALL NOT require reset of FIFO storage array.

Configuration
REQ-022 SHALL with FFT_SER_OVF_STICKY_EN defined hold overflow high from first dropped beat until reset.
REQ-023 SHALL without FFT_SER_OVF_STICKY_EN pulse overflow high for exactly one cycle per dropped beat (cycle after the drop).

Structure
REQ-024 SHALL take DATA_W/IDX_W defaults and a beat struct typedef (4-lane r/i per column plus two indices) from shared package fft_pkg.
REQ-025 SHALL instantiate one sub-module fft_beat_fifo (synchronous FIFO, push/pop/full/empty/count); lane mux and state machine in top.

Verification
REQ-026 SHALL cover: single beat, col1_r lane k = 0x100+k, col2_r lane k = 0x200+k, indices 5/6, out_ready=1 -> 8 transfers, out_index 20,21,22,23,24,25,26,27, out_last only on 8th, out_valid cycle after in_valid.
REQ-027 SHALL cover: out_ready=0 for 5 cycles mid-beat at lane 3 -> out_r/out_index held at lane-3 values, no skipped or repeated sample.
REQ-028 SHALL cover: 6 beats on consecutive cycles, DEPTH=4, out_ready=0 -> fifo_count reaches 4, beats 5 and 6 dropped, overflow sticky (macro on) or two 1-cycle pulses (macro off); draining yields beats 1-4 only.
REQ-029 SHALL cover: FIFO full, in_valid coincident with last-sample transfer -> beat accepted, fifo_count stays 4, overflow stays 0.
REQ-030 SHALL cover: rst_n asserted at lane 5 of a beat with 2 entries queued -> outputs zero immediately; after release out_valid stays 0 until next in_valid.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths, beat record and state encoding for the FFT result serializer.
package fft_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 11;
    localparam int LANES      = 4;

    // One recover-stage beat: four lanes of complex samples for each of two columns.
    typedef struct packed {
        logic [LANES-1:0][DATA_W_DEF-1:0] c1_r;
        logic [LANES-1:0][DATA_W_DEF-1:0] c1_i;
        logic [LANES-1:0][DATA_W_DEF-1:0] c2_r;
        logic [LANES-1:0][DATA_W_DEF-1:0] c2_i;
        logic [IDX_W_DEF-1:0]             idx1;
        logic [IDX_W_DEF-1:0]             idx2;
    } beat_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fft_beat_fifo.sv
// Synchronous beat FIFO; storage is not reset, pointers and count are.
module fft_beat_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fft_result_serializer.sv
// Serializes 8-sample FFT beats into one complex sample per handshake.
// Build option: FFT_SER_OVF_STICKY_EN makes overflow sticky until reset.
//   state  | meaning
//   S_IDLE | FIFO empty, out_valid low
//   S_SEND | head beat presented at lane_q, out_valid high
module fft_result_serializer
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [4*DATA_W-1:0]       in_col1_r,
    input  logic [4*DATA_W-1:0]       in_col1_i,
    input  logic [4*DATA_W-1:0]       in_col2_r,
    input  logic [4*DATA_W-1:0]       in_col2_i,
    input  logic [IDX_W-1:0]          in_index_col1,
    input  logic [IDX_W-1:0]          in_index_col2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_r,
    output logic [DATA_W-1:0]         out_i,
    output logic [IDX_W+1:0]          out_index,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    ser_state_e state_q, state_d;
    logic [2:0] lane_q, lane_d;
    logic       ovf_q;
    beat_t      wr_beat, rd_beat;
    logic       fifo_full, fifo_empty;
    logic       fire, push, pop, drop;

    assign wr_beat.c1_r = in_col1_r;
    assign wr_beat.c1_i = in_col1_i;
    assign wr_beat.c2_r = in_col2_r;
    assign wr_beat.c2_i = in_col2_i;
    assign wr_beat.idx1 = in_index_col1;
    assign wr_beat.idx2 = in_index_col2;

    // A full FIFO still takes a beat when the head is leaving the same cycle.
    assign fire = (state_q == S_SEND) && out_ready;
    assign pop  = fire && (lane_q == 3'd7);
    assign push = in_valid && (!fifo_full || pop);
    assign drop = in_valid && fifo_full && !pop;

    fft_beat_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wr_beat),
        .pop_i   (pop),
        .rdata_o (rd_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            S_IDLE: begin
                if (push || !fifo_empty) state_d = S_SEND;
            end
            S_SEND: begin
                if (fire) lane_d = lane_q + 3'd1;
                if (pop && (fifo_count == CW'(1)) && !push) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lane_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
`ifdef FFT_SER_OVF_STICKY_EN
            ovf_q   <= ovf_q | drop;
`else
            ovf_q   <= drop;
`endif
        end
    end

    // Outputs are gated by state so reset zeroes them without waiting for a clock.
    always_comb begin
        out_valid = 1'b0;
        out_r     = '0;
        out_i     = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (state_q == S_SEND) begin
            out_valid = 1'b1;
            out_last  = (lane_q == 3'd7);
            if (lane_q[2]) begin
                out_r     = rd_beat.c2_r[lane_q[1:0]];
                out_i     = rd_beat.c2_i[lane_q[1:0]];
                out_index = {rd_beat.idx2, lane_q[1:0]};
            end else begin
                out_r     = rd_beat.c1_r[lane_q[1:0]];
                out_i     = rd_beat.c1_i[lane_q[1:0]];
                out_index = {rd_beat.idx1, lane_q[1:0]};
            end
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_fft_result_serializer.sv
// Self-checking bench: beat table plus a sample scoreboard popped on each transfer.
module tb_fft_result_serializer;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 11;
    localparam int DEPTH  = 4;

    logic                   clk, rst_n;
    logic                   in_valid;
    logic [4*DATA_W-1:0]    in_col1_r, in_col1_i, in_col2_r, in_col2_i;
    logic [IDX_W-1:0]       in_index_col1, in_index_col2;
    logic                   out_valid, out_ready, out_last, overflow;
    logic [DATA_W-1:0]      out_r, out_i;
    logic [IDX_W+1:0]       out_index;
    logic [$clog2(DEPTH):0] fifo_count;

    fft_result_serializer #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_col1_r(in_col1_r), .in_col1_i(in_col1_i),
        .in_col2_r(in_col2_r), .in_col2_i(in_col2_i),
        .in_index_col1(in_index_col1), .in_index_col2(in_index_col2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_index(out_index), .out_last(out_last),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [31:0] i;
        logic [12:0] idx;
        logic        last;
    } samp_t;

    // Inputs (bases, indices) and expected first out_index of each column.
    typedef struct {
        logic [31:0] b1;
        logic [31:0] b2;
        logic [10:0] i1;
        logic [10:0] i2;
        logic [12:0] e1;
        logic [12:0] e2;
    } vec_t;

    samp_t sb[$];
    vec_t  vecs[8];
    int    errors = 0;
    int    checks = 0;

    `ifdef FFT_SER_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
    `else
    localparam bit STICKY = 1'b0;
    `endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input vec_t v, input bit accept);
        samp_t s;
        for (int k = 0; k < 4; k++) begin
            in_col1_r[k*32 +: 32] = v.b1 + 32'(k);
            in_col1_i[k*32 +: 32] = v.b1 + 32'h8000_0000 + 32'(k);
            in_col2_r[k*32 +: 32] = v.b2 + 32'(k);
            in_col2_i[k*32 +: 32] = v.b2 + 32'h8000_0000 + 32'(k);
        end
        in_index_col1 = v.i1;
        in_index_col2 = v.i2;
        in_valid      = 1'b1;
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                s.r    = (k < 4) ? v.b1 + 32'(k) : v.b2 + 32'(k - 4);
                s.i    = s.r + 32'h8000_0000;
                s.idx  = (k < 4) ? v.e1 + 13'(k) : v.e2 + 13'(k - 4);
                s.last = (k == 7);
                sb.push_back(s);
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_budget", 64'(n < budget), 64'd1);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got r=%0h idx=%0d expected no sample", out_r, out_index);
            end else begin
                samp_t s;
                s = sb.pop_front();
                if (out_r !== s.r || out_i !== s.i || out_index !== s.idx || out_last !== s.last) begin
                    errors++;
                    $display("FAIL xfer_sample: got r=%0h i=%0h idx=%0d last=%0b expected r=%0h i=%0h idx=%0d last=%0b",
                             out_r, out_i, out_index, out_last, s.r, s.i, s.idx, s.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 11'd5,    11'd6,    13'd20,   13'd24};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 11'd7,    11'd8,    13'd28,   13'd32};
        vecs[2] = '{32'hDEAD_0000, 32'hBEEF_0000, 11'd2047, 11'd0,    13'd8188, 13'd0};
        vecs[3] = '{32'hFFFF_FFF0, 32'h7FFF_FFF8, 11'd1,    11'd2047, 13'd4,    13'd8188};
        vecs[4] = '{32'h1111_0000, 32'h2222_0000, 11'd100,  11'd101,  13'd400,  13'd404};
        vecs[5] = '{32'h3333_0000, 32'h4444_0000, 11'd200,  11'd201,  13'd800,  13'd804};
        vecs[6] = '{32'h5555_0000, 32'h6666_0000, 11'd300,  11'd301,  13'd1200, 13'd1204};
        vecs[7] = '{32'hAAAA_0000, 32'hBBBB_0000, 11'd42,   11'd43,   13'd168,  13'd172};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_col1_r = '0; in_col1_i = '0; in_col2_r = '0; in_col2_i = '0;
        in_index_col1 = '0; in_index_col2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_r", 64'(out_r), 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beats, free-flowing output, one-cycle latency.
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            drive_beat(vecs[v], 1'b1);
            @(negedge clk);
            check("lat_valid_same_cycle", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("lat_valid_next_cycle", 64'(out_valid), 64'd1);
            check("first_index", 64'(out_index), 64'(vecs[v].e1));
            wait_drain(40);
        end

        // Back-pressure held at lane 3.
        out_ready = 1'b0;
        drive_beat(vecs[4], 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_r", 64'(out_r), 64'(sb[0].r));
            check("hold_index", 64'(out_index), 64'(vecs[4].e1 + 13'd3));
        end
        out_ready = 1'b1;
        wait_drain(40);

        // Full FIFO, new beat coincident with the last-sample pop.
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive_beat(vecs[b], 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_count", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("full_last_presented", 64'(out_last), 64'd1);
        drive_beat(vecs[4], 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pushpop_count", 64'(fifo_count), 64'd4);
        check("pushpop_overflow", 64'(overflow), 64'd0);
        wait_drain(100);

        // Six consecutive beats into a stalled FIFO: two are dropped.
        out_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            drive_beat(vecs[b], b < 4);
            @(posedge clk); #1;
            check("ovf_fill_count", 64'(fifo_count), 64'((b < 4) ? b + 1 : 4));
            check("ovf_flag", 64'(overflow), 64'(b >= 4));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("ovf_after_drops", 64'(overflow), 64'(STICKY));
        out_ready = 1'b1;
        wait_drain(100);
        check("ovf_after_drain", 64'(overflow), 64'(STICKY));

        // Reset in the middle of a beat with two more queued.
        out_ready = 1'b0;
        for (int b = 5; b < 8; b++) begin
            drive_beat(vecs[b], 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_index", 64'(out_index), 64'(vecs[5].e2 + 13'd1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_out_r", 64'(out_r), 64'd0);
        check("midrst_out_i", 64'(out_i), 64'd0);
        check("midrst_index", 64'(out_index), 64'd0);
        check("midrst_last", 64'(out_last), 64'd0);
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        drive_beat(vecs[1], 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
